// File: rtl/nms_score_fetch.sv
// NMS score responder: maps neighbour index to score-memory address, captures the
// returned scores into nine slots, and on readen emits a registered corner verdict.
// Optional build macro NMS_TIE_BREAK_EN: plateau ties resolve to the earlier raster pixel.
module nms_score_fetch #(
   parameter int IMG_WIDTH = 300,
   parameter int SCORE_W   = 8
) (
   input  logic               clock,
   input  logic               nReset,
   input  logic [14:0]        refAddr,
   input  logic [3:0]         adjNumber,
   input  logic [3:0]         regAddr,
   input  logic               readen,
   output logic [14:0]        memAddr,
   input  logic [SCORE_W-1:0] memData,
   output logic               nmsValid,
   output logic               isCorner,
   output logic               nmsErr
);

   localparam logic [14:0] ROW = 15'(IMG_WIDTH);
   localparam int          NSLOT = 9;
   localparam int          CENTRE = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_EVAL    = 2'd2
   } state_t;

   state_t             r_state;
   logic [14:0]        r_addr_hold;
   logic [SCORE_W-1:0] r_slot [NSLOT];
   logic [NSLOT-1:0]   r_wmask;

   logic [14:0]        w_addr;
   logic               w_wr;
   logic [SCORE_W-1:0] w_slot_nx [NSLOT];
   logic [NSLOT-1:0]   w_mask_nx;
   logic               w_beats;
   logic               w_corner;

   // Address offsets wrap mod 2^15; idle indices replay the last valid address.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_addr = r_addr_hold;
      case (adjNumber)
         4'd0:    w_addr = refAddr - ROW - 15'd1;
         4'd1:    w_addr = refAddr - ROW;
         4'd2:    w_addr = refAddr - ROW + 15'd1;
         4'd3:    w_addr = refAddr - 15'd1;
         4'd4:    w_addr = refAddr + 15'd1;
         4'd5:    w_addr = refAddr + ROW - 15'd1;
         4'd6:    w_addr = refAddr + ROW;
         4'd7:    w_addr = refAddr + ROW + 15'd1;
         4'd8:    w_addr = refAddr;
         default: w_addr = r_addr_hold;
      endcase
   end

   assign memAddr = w_addr;
   assign w_wr    = (regAddr <= 4'd8);

   // Forward this cycle's write so a readen in the same cycle evaluates the completed set.
   always_comb begin
      for (int i = 0; i < NSLOT; i++) begin
         w_slot_nx[i] = (w_wr && (regAddr == 4'(i))) ? memData : r_slot[i];
      end
      w_mask_nx = r_wmask;
      if (w_wr) begin
         w_mask_nx = r_wmask | (NSLOT'(1) << regAddr);
      end
   end

   always_comb begin
      w_beats = 1'b1;
      for (int i = 0; i < CENTRE; i++) begin
`ifdef NMS_TIE_BREAK_EN
         // Neighbours 0-3 precede the centre in raster order and must lose strictly.
         if (i < 4) begin
            if (!(w_slot_nx[CENTRE] > w_slot_nx[i])) w_beats = 1'b0;
         end else begin
            if (!(w_slot_nx[CENTRE] >= w_slot_nx[i])) w_beats = 1'b0;
         end
`else
         if (!(w_slot_nx[CENTRE] > w_slot_nx[i])) w_beats = 1'b0;
`endif
      end
      w_corner = (w_slot_nx[CENTRE] != '0) && w_beats;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         r_state     <= ST_IDLE;
         r_addr_hold <= '0;
         r_wmask     <= '0;
         nmsValid    <= 1'b0;
         isCorner    <= 1'b0;
         nmsErr      <= 1'b0;
         // NOTE: the slot array is reset explicitly because a reset mid-pass must discard captured scores.
         for (int i = 0; i < NSLOT; i++) begin
            r_slot[i] <= '0;
         end
      end else begin
         r_addr_hold <= w_addr;
         for (int i = 0; i < NSLOT; i++) begin
            r_slot[i] <= w_slot_nx[i];
         end

         nmsValid <= readen;
         isCorner <= readen & w_corner;
         nmsErr   <= readen & ~(&w_mask_nx);
         r_wmask  <= readen ? '0 : w_mask_nx;

         case (r_state)
            ST_IDLE: begin
               if (readen)    r_state <= ST_EVAL;
               else if (w_wr) r_state <= ST_COLLECT;
            end
            ST_COLLECT: begin
               if (readen) r_state <= ST_EVAL;
            end
            ST_EVAL: begin
               r_state <= readen ? ST_EVAL : ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nms_score_fetch.sv
// Scoreboard bench for nms_score_fetch: stimulus pushes expected verdicts, a monitor pops them.
module tb_nms_score_fetch;

   localparam int W  = 300;
   localparam int SW = 8;

   logic          clock = 1'b0;
   logic          nReset;
   logic [14:0]   refAddr;
   logic [3:0]    adjNumber;
   logic [3:0]    regAddr;
   logic          readen;
   logic [14:0]   memAddr;
   logic [SW-1:0] memData;
   logic          nmsValid;
   logic          isCorner;
   logic          nmsErr;

   nms_score_fetch #(.IMG_WIDTH(W), .SCORE_W(SW)) dut (
      .clock     (clock),
      .nReset    (nReset),
      .refAddr   (refAddr),
      .adjNumber (adjNumber),
      .regAddr   (regAddr),
      .readen    (readen),
      .memAddr   (memAddr),
      .memData   (memData),
      .nmsValid  (nmsValid),
      .isCorner  (isCorner),
      .nmsErr    (nmsErr)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic corner;
      logic err;
      int   due;
   } exp_t;

   typedef int score_arr_t [9];

   exp_t          sb_q [$];
   int            n_checks = 0;
   int            n_fail   = 0;
   int            cyc      = 0;
   logic [SW-1:0] m_slot [9];
   bit            m_wr [9];
   logic [14:0]   m_last_addr;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [14:0] ref_addr(input logic [14:0] r, input int k);
      int off;
      case (k)
         0: off = -W - 1;
         1: off = -W;
         2: off = -W + 1;
         3: off = -1;
         4: off = 1;
         5: off = W - 1;
         6: off = W;
         7: off = W + 1;
         default: off = 0;
      endcase
      return 15'(int'(r) + off);
   endfunction

   function automatic exp_t model_verdict();
      exp_t e;
      e.corner = (m_slot[8] != 0);
      for (int i = 0; i < 8; i++) begin
`ifdef NMS_TIE_BREAK_EN
         if (i < 4 ? !(m_slot[8] > m_slot[i]) : !(m_slot[8] >= m_slot[i])) e.corner = 1'b0;
`else
         if (!(m_slot[8] > m_slot[i])) e.corner = 1'b0;
`endif
      end
      e.err = 1'b0;
      for (int i = 0; i < 9; i++) if (!m_wr[i]) e.err = 1'b1;
      e.due = cyc + 1;
      return e;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 9; i++) begin
         m_slot[i] = '0;
         m_wr[i]   = 1'b0;
      end
      m_last_addr = '0;
   endtask

   // One sequencer cycle: drive, check the combinational address, update the model.
   task automatic step(input int adj, input logic [14:0] ra, input int slot,
                       input logic [SW-1:0] data, input bit rd);
      @(posedge clock);
      #1;
      adjNumber = 4'(adj);
      refAddr   = ra;
      regAddr   = 4'(slot);
      memData   = data;
      readen    = rd;
      #1;
      if (adj <= 8) m_last_addr = ref_addr(ra, adj);
      check($sformatf("memAddr adj=%0d ref=%0d", adj, ra), memAddr, m_last_addr);
      if (slot <= 8) begin
         m_slot[slot] = data;
         m_wr[slot]   = 1'b1;
      end
      if (rd) begin
         sb_q.push_back(model_verdict());
         for (int i = 0; i < 9; i++) m_wr[i] = 1'b0;
      end
   endtask

   // Full pass: address k, capture k a cycle later; readen rides with the centre write.
   task automatic run_pass(input logic [14:0] ra, input score_arr_t sc,
                           input bit [8:0] skip, input bit b2b);
      for (int s = 0; s <= 9; s++) begin
         int slot;
         slot = (s > 0 && !skip[s-1]) ? s - 1 : 15;
         step(s < 9 ? s : 15, ra, slot, (s > 0) ? SW'(sc[s-1]) : '0, s == 9);
      end
      if (b2b) step(15, ra, 15, '0, 1'b1);
      step(15, ra, 15, '0, 1'b0);
   endtask

   // Monitor: every verdict pulse must match the oldest expectation and its due cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (nReset === 1'b1 && nmsValid === 1'b1) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_valid: got nmsValid=1, expected 0 (t=%0t)", $time);
            end else begin
               e = sb_q.pop_front();
               check("verdict_cycle", cyc, e.due);
               check("isCorner", isCorner, e.corner);
               check("nmsErr", nmsErr, e.err);
            end
         end
      end
   end

   initial begin
      score_arr_t sc;
      int         drain;

      nReset    = 1'b0;
      refAddr   = '0;
      adjNumber = 4'd15;
      regAddr   = 4'd15;
      memData   = '0;
      readen    = 1'b0;
      model_reset();
      repeat (3) @(negedge clock);
      check("reset nmsValid", nmsValid, 0);
      check("reset isCorner", isCorner, 0);
      check("reset nmsErr", nmsErr, 0);
      check("reset memAddr hold", memAddr, 0);
      @(posedge clock);
      #1 nReset = 1'b1;

      step(0, 15'd0, 15, '0, 1'b0);
      check("wrap memAddr", memAddr, 15'h7ED3);

      sc = '{10, 20, 30, 40, 50, 60, 70, 80, 90};
      run_pass(15'd1000, sc, 9'h000, 1'b0);
      sc[5] = 95;
      run_pass(15'd1000, sc, 9'h000, 1'b0);
      sc = '{10, 20, 30, 40, 50, 60, 90, 80, 90};
      run_pass(15'd2000, sc, 9'h000, 1'b0);
      sc = '{10, 90, 30, 40, 50, 60, 70, 80, 90};
      run_pass(15'd2000, sc, 9'h000, 1'b0);
      sc = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      run_pass(15'd5, sc, 9'h000, 1'b0);
      sc = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
      run_pass(15'd4000, sc, 9'h010, 1'b0);
      run_pass(15'd4000, sc, 9'h000, 1'b1);

      // Interrupted pass: slots 0-3 captured, then reset; no verdict may follow.
      sc = '{200, 200, 200, 200, 1, 1, 1, 1, 100};
      for (int s = 0; s <= 4; s++) step(s, 15'd3000, s > 0 ? s - 1 : 15, SW'(s > 0 ? sc[s-1] : 0), 1'b0);
      @(posedge clock);
      #1;
      nReset    = 1'b0;
      adjNumber = 4'd15;
      regAddr   = 4'd15;
      readen    = 1'b0;
      model_reset();
      #1;
      check("midreset nmsValid", nmsValid, 0);
      check("midreset memAddr hold", memAddr, 0);
      repeat (2) @(posedge clock);
      #1 nReset = 1'b1;
      sc = '{5, 6, 7, 8, 9, 10, 11, 12, 50};
      run_pass(15'd3000, sc, 9'h000, 1'b0);

      for (int p = 0; p < 40; p++) begin
         bit [8:0] skip;
         for (int i = 0; i < 8; i++) sc[i] = int'($urandom_range(0, 7));
         sc[8] = int'($urandom_range(0, 8));
         skip  = '0;
         for (int i = 0; i < 9; i++) skip[i] = ($urandom_range(0, 9) == 0);
         run_pass(15'($urandom), sc, skip, $urandom_range(0, 7) == 0);
      end

      drain = 0;
      while (sb_q.size() > 0 && drain < 20) begin
         @(negedge clock);
         drain++;
      end
      if (sb_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: got %0d verdicts outstanding, expected 0", sb_q.size());
      end
      repeat (2) @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
